use_wire: RTL and testbench
===========================

USE_WIRE -- requirements
Module: use_wire

Interface
REQ-001 Parameter CNT_W, default 8: width of the output-change counter, legal range 2..16.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port A  input  1  data operand A.
REQ-005 Port B  input  1  data operand B.
REQ-006 Port C  input  1  data operand C.
REQ-007 Port D  input  1  data operand D.
REQ-008 Port f  output  1  combinational result, net-driven.
REQ-009 Port f_q  output  1  f registered one clk later.
REQ-010 Port f_rise  output  1  one-cycle pulse, f_q 0->1 transition.
REQ-011 Port f_fall  output  1  one-cycle pulse, f_q 1->0 transition.
REQ-012 Port chg_cnt  output  CNT_W  saturating count of f_q transitions.
REQ-013 Port in_q  output  4  registered {A,B,C,D}, A in MSB.

Function
REQ-014 f SHALL equal (A AND B) OR (C AND D), purely combinational, no clock dependence, zero-cycle latency.
REQ-015 f SHALL be X whenever an input term needed to resolve it is X/Z, i.e. no forced default on unknown inputs.
REQ-016 f_q SHALL capture f on each rising clk edge (latency 1 cycle).
REQ-017 in_q SHALL capture {A,B,C,D} on each rising clk edge.
REQ-018 f_rise SHALL be 1 for exactly the cycle after f_q changes 0->1; f_fall likewise for 1->0; never both high.
REQ-019 chg_cnt SHALL increment by 1 in the cycle a rise or fall pulse is generated; saturate at 2^CNT_W-1, no wrap.
REQ-020 Input changes between clock edges SHALL affect f immediately but registered outputs only at the next edge; glitches shorter than a cycle are not counted.

Reset
REQ-021 While rst_n=0: f_q=0, in_q=4'b0000, f_rise=0, f_fall=0, chg_cnt=0, asynchronously, independent of clk.
REQ-022 f SHALL remain combinationally valid during reset.
REQ-023 First edge after rst_n release SHALL load f_q from f; a 0->1 transition on that edge produces f_rise (reset value 0 is the reference).
REQ-024 Reset asserted mid-operation SHALL clear the counter and pulses immediately.

Configuration
REQ-025 Macro USE_WIRE_CNT_EN: when defined, chg_cnt operates per REQ-019; when undefined, the counter logic is omitted and chg_cnt is tied to 0; all other behaviour is identical.

Verification
REQ-026 A,B,C,D = 1,0,1,0 -> f=0; after next edge f_q=0, in_q=4'b1010, no pulses.
REQ-027 Sequence 1010, 0001, 1110, 1001 applied one per cycle -> f = 0,0,1,0; f_q follows one cycle later; f_rise once, f_fall once; chg_cnt=2 (with USE_WIRE_CNT_EN).
REQ-028 All inputs 1 after reset release -> f=1, first edge f_q=1 with f_rise=1, chg_cnt=1.
REQ-029 CNT_W=2, toggle f every cycle for 10 cycles -> chg_cnt reaches 3 and holds.
REQ-030 rst_n pulled low between edges while f_q=1, chg_cnt=2 -> all registered outputs 0 immediately, f unchanged.
REQ-031 Build without USE_WIRE_CNT_EN, repeat REQ-027 -> chg_cnt=0 throughout; f, f_q, pulses identical.

Source files
------------

// File: rtl/use_wire.sv
// use_wire: combinational (A&B)|(C&D) plus registered copy, edge pulses and input capture.
// Optional saturating output-change counter is built only when USE_WIRE_CNT_EN is defined.
module use_wire #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output wire              f,
    output logic             f_q,
    output logic             f_rise,
    output logic             f_fall,
    output logic [CNT_W-1:0] chg_cnt,
    output logic [3:0]       in_q
);

    // Plain gate expression so unknown inputs propagate as X.
    assign f = (A & B) | (C & D);

    logic       f_d;
    logic       rise_d;
    logic       fall_d;
    logic [3:0] in_d;

    always_comb begin
        f_d    = f;
        in_d   = {A, B, C, D};
        rise_d = f & ~f_q;
        fall_d = ~f & f_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q    <= 1'b0;
            f_rise <= 1'b0;
            f_fall <= 1'b0;
            in_q   <= 4'b0000;
        end else begin
            f_q    <= f_d;
            f_rise <= rise_d;
            f_fall <= fall_d;
            in_q   <= in_d;
        end
    end

`ifdef USE_WIRE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counts on the same edge that launches a rise or fall pulse.
    always_comb begin
        cnt_d = cnt_q;
        if ((rise_d || fall_d) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign chg_cnt = cnt_q;
`else
    assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_use_wire.sv
// Directed bench for use_wire: reset, live f, pulses, glitch immunity, async reset, saturation.
module tb_use_wire;

    logic       clk;
    logic       rst_n;
    logic       a, b, c, d;
    wire        f;
    logic       f_q, f_rise, f_fall;
    logic [7:0] chg_cnt;
    logic [3:0] in_q;

    logic       a2, b2, c2, d2;
    wire        f2;
    logic       f_q2, f_rise2, f_fall2;
    logic [1:0] chg_cnt2;
    logic [3:0] in_q2;

    int checks;
    int failures;

`ifdef USE_WIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    use_wire #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d),
        .f(f), .f_q(f_q), .f_rise(f_rise), .f_fall(f_fall),
        .chg_cnt(chg_cnt), .in_q(in_q)
    );

    use_wire #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .C(c2), .D(d2),
        .f(f2), .f_q(f_q2), .f_rise(f_rise2), .f_fall(f_fall2),
        .chg_cnt(chg_cnt2), .in_q(in_q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ec(input int v);
        return CNT_EN ? 16'(v) : 16'd0;
    endfunction

    task automatic set_in(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq_v    [4] = '{4'hA, 4'h1, 4'hE, 4'h9};
    logic       seq_f    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       seq_rise [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       seq_fall [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         seq_cnt  [4] = '{0, 0, 1, 2};

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        set_in(4'h0);
        {a2, b2, c2, d2} = 4'h0;

        // Reset state
        tick();
        tick();
        chk("rst_f_q", 16'(f_q), 16'd0);
        chk("rst_in_q", 16'(in_q), 16'd0);
        chk("rst_rise", 16'(f_rise), 16'd0);
        chk("rst_fall", 16'(f_fall), 16'd0);
        chk("rst_cnt", 16'(chg_cnt), 16'd0);
        chk("rst_f", 16'(f), 16'd0);

        // f stays live in reset while registers hold
        set_in(4'hF);
        #1;
        chk("rst_f_live", 16'(f), 16'd1);
        tick();
        chk("rst_f_q_hold", 16'(f_q), 16'd0);
        chk("rst_in_q_hold", 16'(in_q), 16'd0);

        // Release with all inputs high: first edge produces a rise
        #2 rst_n = 1'b1;
        tick();
        chk("first_f_q", 16'(f_q), 16'd1);
        chk("first_rise", 16'(f_rise), 16'd1);
        chk("first_fall", 16'(f_fall), 16'd0);
        chk("first_cnt", 16'(chg_cnt), ec(1));
        chk("first_in_q", 16'(in_q), 16'hF);
        tick();
        chk("hold_rise", 16'(f_rise), 16'd0);
        chk("hold_f_q", 16'(f_q), 16'd1);
        chk("hold_cnt", 16'(chg_cnt), ec(1));

        set_in(4'h0);
        #1;
        chk("f_zero", 16'(f), 16'd0);
        tick();
        chk("fall_pulse", 16'(f_fall), 16'd1);
        chk("fall_rise_lo", 16'(f_rise), 16'd0);
        chk("fall_f_q", 16'(f_q), 16'd0);
        chk("fall_cnt", 16'(chg_cnt), ec(2));

        set_in(4'h3);
        tick();
        chk("cd_rise", 16'(f_rise), 16'd1);
        chk("cd_f_q", 16'(f_q), 16'd1);
        chk("cd_cnt", 16'(chg_cnt), ec(3));

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_f_q", 16'(f_q), 16'd0);
        chk("async_rise", 16'(f_rise), 16'd0);
        chk("async_fall", 16'(f_fall), 16'd0);
        chk("async_cnt", 16'(chg_cnt), 16'd0);
        chk("async_in_q", 16'(in_q), 16'd0);
        chk("async_f", 16'(f), 16'd1);

        // Single vector 1010 from fresh reset
        set_in(4'hA);
        tick();
        #2 rst_n = 1'b1;
        #1;
        chk("v1010_f", 16'(f), 16'd0);
        tick();
        chk("v1010_f_q", 16'(f_q), 16'd0);
        chk("v1010_in_q", 16'(in_q), 16'hA);
        chk("v1010_rise", 16'(f_rise), 16'd0);
        chk("v1010_fall", 16'(f_fall), 16'd0);
        chk("v1010_cnt", 16'(chg_cnt), 16'd0);

        // Four-vector sequence
        for (int i = 0; i < 4; i++) begin
            set_in(seq_v[i]);
            #1;
            chk($sformatf("seq%0d_f", i), 16'(f), 16'(seq_f[i]));
            tick();
            chk($sformatf("seq%0d_f_q", i), 16'(f_q), 16'(seq_f[i]));
            chk($sformatf("seq%0d_in_q", i), 16'(in_q), 16'(seq_v[i]));
            chk($sformatf("seq%0d_rise", i), 16'(f_rise), 16'(seq_rise[i]));
            chk($sformatf("seq%0d_fall", i), 16'(f_fall), 16'(seq_fall[i]));
            chk($sformatf("seq%0d_cnt", i), 16'(chg_cnt), ec(seq_cnt[i]));
        end

        // Sub-cycle glitch on f must not reach the registers
        set_in(4'hC);
        #1;
        chk("glitch_f_hi", 16'(f), 16'd1);
        #2;
        set_in(4'h9);
        #1;
        chk("glitch_f_lo", 16'(f), 16'd0);
        tick();
        chk("glitch_f_q", 16'(f_q), 16'd0);
        chk("glitch_rise", 16'(f_rise), 16'd0);
        chk("glitch_cnt", 16'(chg_cnt), ec(2));

        // Narrow counter saturates at 3
        for (int k = 1; k <= 10; k++) begin
            {a2, b2, c2, d2} = (k % 2 == 1) ? 4'hC : 4'h0;
            tick();
            chk($sformatf("sat%0d_f_q", k), 16'(f_q2), 16'(k % 2));
            chk($sformatf("sat%0d_rise", k), 16'(f_rise2), 16'(k % 2));
            chk($sformatf("sat%0d_fall", k), 16'(f_fall2), 16'((k + 1) % 2));
            chk($sformatf("sat%0d_cnt", k), 16'(chg_cnt2), ec((k < 3) ? k : 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
